// File: rtl/reset_req_gen.sv
// Turns a bouncy active-low pushbutton (long-press) or a one-cycle software request
// into a fixed-width active-low reset request pulse for reset_gen.
module reset_req_gen #(
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 16,
  parameter int HoldCycles     = 64,
  parameter int PulseCycles    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       sw_req,
  output logic       req_rst_n,
  output logic       busy,
  output logic [7:0] req_count
);

  localparam int DbW    = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int HoldW  = (HoldCycles > 1)     ? $clog2(HoldCycles)     : 1;
  localparam int PulseW = (PulseCycles > 1)    ? $clog2(PulseCycles)    : 1;

  localparam logic [DbW-1:0]    DbMax    = DbW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0]  HoldMax  = HoldW'(HoldCycles - 1);
  localparam logic [PulseW-1:0] PulseMax = PulseW'(PulseCycles - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD         = 2'd1,
    PULSE        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  logic [SyncStages-1:0] sync_q;
  logic                  btn_s;
  logic                  btn_db_q, btn_db_d;
  logic [DbW-1:0]        db_cnt_q, db_cnt_d;
  state_e                state_q, state_d;
  logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [PulseW-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic                  req_rst_n_q, busy_q;
  logic [7:0]            req_count_q;

  assign btn_s = sync_q[SyncStages-1];

  // Synchroniser resets to "released" so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, so order of statements never matters.
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SyncStages-2:0], btn_n};
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == DbMax) btn_db_d = btn_s;
      else                   db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sw_req) begin
          state_d     = PULSE;
          pulse_cnt_d = '0;
        end else if (!btn_db_q) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (sw_req || (!btn_db_q && hold_cnt_q == HoldMax)) begin
          state_d     = PULSE;
          pulse_cnt_d = '0;
        end else if (btn_db_q) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      PULSE: begin
        // Software requests are deliberately ignored until the pulse completes.
        if (pulse_cnt_q == PulseMax) state_d = btn_db_q ? IDLE : WAIT_RELEASE;
        else                         pulse_cnt_d = pulse_cnt_q + 1'b1;
      end
      WAIT_RELEASE: begin
        if (sw_req) begin
          state_d     = PULSE;
          pulse_cnt_d = '0;
        end else if (btn_db_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q    <= 1'b1;
      db_cnt_q    <= '0;
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      req_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      req_count_q <= '0;
    end else begin
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      // Outputs are registered from the next state so they line up with state_q.
      req_rst_n_q <= (state_d != PULSE);
      busy_q      <= (state_d != IDLE);
      if (state_d == PULSE && state_q != PULSE && req_count_q != 8'hFF)
        req_count_q <= req_count_q + 8'd1;
    end
  end

  assign req_rst_n = req_rst_n_q;
  assign busy      = busy_q;
  assign req_count = req_count_q;

endmodule
